// File: rtl/prog_loader_pkg.sv
// Shared types and constants for the program loader: FSM state encoding
// and the rule that a length byte of zero stands for 256 instructions.
package prog_loader_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN,
    S_HI,
    S_LO,
    S_WRITE,
    S_CSUM,
    S_RUN
  } state_e;

  localparam logic [8:0] LEN_ZERO_COUNT = 9'd256;

  function automatic logic [8:0] len_decode(input logic [7:0] len_byte);
    return (len_byte == 8'd0) ? LEN_ZERO_COUNT : {1'b0, len_byte};
  endfunction

endpackage

// File: rtl/prog_loader_if.sv
// Byte-stream input, instruction-memory write port and processor control
// outputs of the program loader, bundled as one interface.
interface prog_loader_if #(
  parameter int ADDR_W  = 8,
  parameter int INSTR_W = 12
);

  logic               start;
  logic [7:0]         rx_data;
  logic               rx_valid;
  logic               rx_ready;
  logic               imem_wr;
  logic [ADDR_W-1:0]  imem_addr;
  logic [INSTR_W-1:0] imem_data;
  logic               cpu_rst;
  logic               busy;
  logic               done;
  logic               err;

  // master is the byte source / system side, slave is the loader itself
  modport master (
    output start, rx_data, rx_valid,
    input  rx_ready, imem_wr, imem_addr, imem_data, cpu_rst, busy, done, err
  );

  modport slave (
    input  start, rx_data, rx_valid,
    output rx_ready, imem_wr, imem_addr, imem_data, cpu_rst, busy, done, err
  );

endinterface

// File: rtl/prog_loader.sv
// Program loader: receives LEN, {HI,LO} pairs and a checksum byte, writes
// instructions into instruction memory and releases the processor on success.
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int ADDR_W  = 8,
  parameter int INSTR_W = 12
) (
  input  logic            clk,
  input  logic            rst,
  prog_loader_if.slave    bus
);

  localparam int HI_W = INSTR_W - 8;

  state_e             state_q, state_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [ADDR_W-1:0]  imem_addr_q, imem_addr_d;
  logic [INSTR_W-1:0] imem_data_q, imem_data_d;
  logic [HI_W-1:0]    hi_q, hi_d;
  logic [8:0]         len_q, len_d;
  logic [8:0]         cnt_q, cnt_d;
  logic [7:0]         csum_q, csum_d;
  logic               err_pend_q, err_pend_d;
  logic               cpu_rst_q, cpu_rst_d;
  logic               err_q, err_d;
  logic               done_q, done_d;
  logic               rx_ready;
  logic               accept;

  assign rx_ready = (state_q == S_LEN) || (state_q == S_HI) ||
                    (state_q == S_LO)  || (state_q == S_CSUM);
  assign accept   = rx_ready && bus.rx_valid;

  assign bus.rx_ready  = rx_ready;
  assign bus.imem_wr   = (state_q == S_WRITE);
  assign bus.imem_addr = imem_addr_q;
  assign bus.imem_data = imem_data_q;
  assign bus.cpu_rst   = cpu_rst_q;
  assign bus.busy      = rx_ready || (state_q == S_WRITE);
  assign bus.done      = done_q;
  assign bus.err       = err_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      imem_addr_q <= '0;
      imem_data_q <= '0;
      hi_q        <= '0;
      len_q       <= '0;
      cnt_q       <= '0;
      csum_q      <= '0;
      err_pend_q  <= 1'b0;
      cpu_rst_q   <= 1'b1;
      err_q       <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      imem_addr_q <= imem_addr_d;
      imem_data_q <= imem_data_d;
      hi_q        <= hi_d;
      len_q       <= len_d;
      cnt_q       <= cnt_d;
      csum_q      <= csum_d;
      err_pend_q  <= err_pend_d;
      cpu_rst_q   <= cpu_rst_d;
      err_q       <= err_d;
      done_q      <= done_d;
    end
  end

  // The memory port registers load on the LO byte so they stay frozen
  // while the next instruction is being assembled.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    imem_addr_d = imem_addr_q;
    imem_data_d = imem_data_q;
    hi_d        = hi_q;
    len_d       = len_q;
    cnt_d       = cnt_q;
    csum_d      = csum_q;
    err_pend_d  = err_pend_q;
    cpu_rst_d   = cpu_rst_q;
    err_d       = err_q;
    done_d      = 1'b0;

    case (state_q)
      S_IDLE, S_RUN: begin
        if (bus.start) begin
          state_d    = S_LEN;
          cpu_rst_d  = 1'b1;
          err_d      = 1'b0;
          addr_d     = '0;
          cnt_d      = '0;
          csum_d     = '0;
          err_pend_d = 1'b0;
        end
      end
      S_LEN: begin
        if (accept) begin
          len_d   = len_decode(bus.rx_data);
          state_d = S_HI;
        end
      end
      S_HI: begin
        if (accept) begin
          hi_d   = bus.rx_data[HI_W-1:0];
          csum_d = csum_q ^ bus.rx_data;
          if ((bus.rx_data >> HI_W) != 8'd0) begin
            err_pend_d = 1'b1;
          end
          state_d = S_LO;
        end
      end
      S_LO: begin
        if (accept) begin
          csum_d      = csum_q ^ bus.rx_data;
          imem_addr_d = addr_q;
          imem_data_d = {hi_q, bus.rx_data};
          state_d     = S_WRITE;
        end
      end
      S_WRITE: begin
        addr_d  = addr_q + ADDR_W'(1);
        cnt_d   = cnt_q + 9'd1;
        state_d = ((cnt_q + 9'd1) == len_q) ? S_CSUM : S_HI;
      end
      S_CSUM: begin
        if (accept) begin
          if ((bus.rx_data == csum_q) && !err_pend_q) begin
            state_d   = S_RUN;
            cpu_rst_d = 1'b0;
            done_d    = 1'b1;
          end else begin
            state_d = S_IDLE;
            err_d   = 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_prog_loader.sv
// Scoreboard bench for prog_loader: streams are parsed by a behavioural model
// into expected writes and outcomes, and a monitor checks what the DUT does.
module tb_prog_loader;

  logic clk = 1'b0;
  logic rst = 1'b1;

  prog_loader_if #(.ADDR_W(8), .INSTR_W(12)) bus();

  prog_loader #(.ADDR_W(8), .INSTR_W(12)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [19:0] expWr[$];
  bit          expEnd[$];
  logic [7:0]  stream[$];
  bit          errPrev = 1'b0;
  bit          togglePhase = 1'b0;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  // Monitor: every write and every load outcome must match the scoreboard
  always @(negedge clk) begin
    logic [19:0] e;
    bit          ok;
    if (!rst) begin
      if (bus.imem_wr) begin
        if (expWr.size() == 0) begin
          checkOutput("unexpected write", {bus.imem_addr, bus.imem_data}, 32'hFFFF_FFFF);
        end else begin
          e = expWr.pop_front();
          checkOutput("imem write", {bus.imem_addr, bus.imem_data}, e);
        end
      end
      if (bus.done || (bus.err && !errPrev)) begin
        if (expEnd.size() == 0) begin
          checkOutput("unexpected outcome", {bus.done, bus.err}, 2'b00);
        end else begin
          ok = expEnd.pop_front();
          checkOutput("outcome done/err", {bus.done, bus.err}, ok ? 2'b10 : 2'b01);
          checkOutput("cpu_rst at outcome", bus.cpu_rst, ok ? 1'b0 : 1'b1);
        end
      end
    end
    errPrev = bus.err;
  end

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic startLoad();
    bus.start = 1'b1;
    cycle();
    bus.start = 1'b0;
  endtask

  task automatic sendByte(input logic [7:0] b, input bit toggle);
    bit acc = 1'b0;
    int guard = 0;
    while (!acc && guard < 64) begin
      if (toggle && togglePhase) begin
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'($urandom);
      end else begin
        bus.rx_valid = 1'b1;
        bus.rx_data  = b;
        acc          = bus.rx_ready;
      end
      togglePhase = ~togglePhase;
      cycle();
      guard++;
    end
    bus.rx_valid = 1'b0;
    if (!acc) checkOutput("byte handshake", acc, 1'b1);
  endtask

  // Build a stream of n instructions; optionally put bad high bits in one
  // HI byte and/or corrupt the checksum.
  task automatic makeStream(input int n, input bit hiErr, input bit corrupt);
    logic [7:0] hi, lo, cs;
    int k;
    stream.delete();
    stream.push_back(8'(n));
    cs = 8'h00;
    k  = $urandom_range(0, n - 1);
    for (int i = 0; i < n; i++) begin
      hi = 8'($urandom_range(0, 15));
      if (hiErr && i == k) hi = 8'($urandom_range(16, 255));
      lo = 8'($urandom);
      cs = cs ^ hi ^ lo;
      stream.push_back(hi);
      stream.push_back(lo);
    end
    if (corrupt) cs = cs ^ 8'($urandom_range(1, 255));
    stream.push_back(cs);
  endtask

  // Reference parse of the stream, then drive it and wait for the outcome
  task automatic applyStimulus(input bit toggle, input bit startMid);
    int n;
    logic [7:0] hi, lo, cs;
    bit ok;
    int waitCnt;
    n  = (stream[0] == 8'd0) ? 256 : int'(stream[0]);
    cs = 8'h00;
    ok = 1'b1;
    for (int i = 0; i < n; i++) begin
      hi = stream[1 + 2 * i];
      lo = stream[2 + 2 * i];
      cs = cs ^ hi ^ lo;
      if (hi > 8'h0F) ok = 1'b0;
      expWr.push_back({8'(i % 256), hi[3:0], lo});
    end
    if (stream[2 * n + 1] != cs) ok = 1'b0;
    expEnd.push_back(ok);

    startLoad();
    foreach (stream[i]) begin
      if (startMid && i == 3) startLoad();
      sendByte(stream[i], toggle);
    end
    waitCnt = 0;
    while ((expEnd.size() != 0 || expWr.size() != 0) && waitCnt < 20) begin
      cycle();
      waitCnt++;
    end
    checkOutput("outcome pending", expEnd.size(), 0);
    checkOutput("writes pending", expWr.size(), 0);
    checkOutput("busy after load", bus.busy, 1'b0);
    checkOutput("err after load", bus.err, ok ? 1'b0 : 1'b1);
    expEnd.delete();
    expWr.delete();
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, " cpu_rst"}, bus.cpu_rst, 1'b1);
    checkOutput({tag, " busy"}, bus.busy, 1'b0);
    checkOutput({tag, " done"}, bus.done, 1'b0);
    checkOutput({tag, " err"}, bus.err, 1'b0);
    checkOutput({tag, " imem_wr"}, bus.imem_wr, 1'b0);
    checkOutput({tag, " imem_addr"}, bus.imem_addr, 8'h00);
    checkOutput({tag, " imem_data"}, bus.imem_data, 12'h000);
    checkOutput({tag, " rx_ready"}, bus.rx_ready, 1'b0);
  endtask

  task automatic loadBasic(input logic [7:0] csum);
    stream = '{8'h02, 8'h0A, 8'h05, 8'h03, 8'hFF, csum};
  endtask

  initial begin
    bus.start    = 1'b0;
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
    rst          = 1'b1;
    repeat (2) cycle();
    checkResetValues("reset");
    rst = 1'b0;
    cycle();

    $display("[TB] basic load N=2");
    loadBasic(8'hF3);
    applyStimulus(1'b0, 1'b0);

    $display("[TB] bad checksum");
    loadBasic(8'h00);
    applyStimulus(1'b0, 1'b0);

    $display("[TB] nonzero HI upper bits");
    stream = '{8'h01, 8'h1A, 8'h34, 8'h2E};
    applyStimulus(1'b0, 1'b0);

    $display("[TB] N=0 load of 256 instructions");
    makeStream(256, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0);

    $display("[TB] toggling rx_valid with start mid-load");
    loadBasic(8'hF3);
    applyStimulus(1'b1, 1'b1);

    $display("[TB] reset mid-load");
    loadBasic(8'hF3);
    startLoad();
    for (int i = 0; i < 3; i++) sendByte(stream[i], 1'b0);
    rst = 1'b1;
    #1;
    checkResetValues("mid-load reset");
    cycle();
    rst = 1'b0;
    cycle();
    applyStimulus(1'b0, 1'b0);

    $display("[TB] randomized loads");
    for (int r = 0; r < 20; r++) begin
      makeStream($urandom_range(1, 12), $urandom_range(0, 4) == 0,
                 $urandom_range(0, 4) == 0);
      applyStimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
